// File: rtl/floor_scheduler_if.sv
// ============================================================================
//  Module      : floor_scheduler_if
//  Description : Floor-request bundle between the request handler (master)
//                and the floor scheduler (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface floor_scheduler_if #(
  parameter int NUM_FLOORS  = 10,
  parameter int FLOOR_WIDTH = 4
);
  logic [NUM_FLOORS-1:0]  floor_requests;
  logic                   door_hold;
  logic [FLOOR_WIDTH-1:0] current_floor;
  logic                   clear_current_request;
  logic                   door_open;
  logic                   moving;
  logic                   direction;
  logic                   idle;

  // Request handler side: owns the pending vector and the door-hold button.
  modport master (
    output floor_requests,
    output door_hold,
    input  current_floor,
    input  clear_current_request,
    input  door_open,
    input  moving,
    input  direction,
    input  idle
  );

  // Scheduler side: consumes requests, reports car position and status.
  modport slave (
    input  floor_requests,
    input  door_hold,
    output current_floor,
    output clear_current_request,
    output door_open,
    output moving,
    output direction,
    output idle
  );
endinterface

`default_nettype wire

// File: rtl/floor_scheduler.sv
// ============================================================================
//  Module      : floor_scheduler
//  Description : Direction-preserving sweep scheduler. Moves the car one
//                floor at a time, opens the door at requested floors and
//                pulses clear_current_request to retire the serviced bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module floor_scheduler #(
  parameter int NUM_FLOORS    = 10,
  parameter int FLOOR_WIDTH   = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  floor_scheduler_if.slave   sched_io
);

  localparam logic [1:0] S_EVAL      = 2'd0;
  localparam logic [1:0] S_MOVE_UP   = 2'd1;
  localparam logic [1:0] S_MOVE_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR_OPEN = 2'd3;

  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = $clog2(DOOR_CYCLES);

  localparam logic [TRAVEL_W-1:0]    TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]      DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR   = FLOOR_WIDTH'(NUM_FLOORS - 1);
  localparam logic [FLOOR_WIDTH-1:0] ONE_FLOOR   = FLOOR_WIDTH'(1);

  logic [1:0]             state_q,      state_d;
  logic [FLOOR_WIDTH-1:0] floor_q,      floor_d;
  logic                   dir_q,        dir_d;
  logic                   clear_q,      clear_d;
  logic [TRAVEL_W-1:0]    travel_cnt_q, travel_cnt_d;
  logic [DOOR_W-1:0]      door_cnt_q,   door_cnt_d;

  logic here, above, below;

  // Classify pending requests relative to the car position.
  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (sched_io.floor_requests[i]) begin
        if (i == int'(floor_q)) here  = 1'b1;
        if (i >  int'(floor_q)) above = 1'b1;
        if (i <  int'(floor_q)) below = 1'b1;
      end
    end
  end

  // Next-state logic: sweep priority in EVAL, timed MOVE and DOOR phases.
  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    clear_d      = 1'b0;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    case (state_q)
      S_EVAL: begin
        travel_cnt_d = '0;
        door_cnt_d   = '0;
        if (here) begin
          state_d = S_DOOR_OPEN;
          clear_d = 1'b1;
        end else if (dir_q && above) begin
          state_d = S_MOVE_UP;
        end else if (!dir_q && below) begin
          state_d = S_MOVE_DOWN;
        end else if (above) begin
          dir_d   = 1'b1;
          state_d = S_MOVE_UP;
        end else if (below) begin
          dir_d   = 1'b0;
          state_d = S_MOVE_DOWN;
        end
      end
      S_MOVE_UP: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          state_d      = S_EVAL;
          if (floor_q != TOP_FLOOR) floor_d = floor_q + ONE_FLOOR;
        end else begin
          travel_cnt_d = travel_cnt_q + 1'b1;
        end
      end
      S_MOVE_DOWN: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          travel_cnt_d = '0;
          state_d      = S_EVAL;
          if (floor_q != '0) floor_d = floor_q - ONE_FLOOR;
        end else begin
          travel_cnt_d = travel_cnt_q + 1'b1;
        end
      end
      default: begin
        // Door open: a held door restarts its dwell time.
        if (sched_io.door_hold) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          door_cnt_d = '0;
          state_d    = S_EVAL;
        end else begin
          door_cnt_d = door_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with asynchronous reset to idle at floor 0, heading up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_EVAL;
      floor_q      <= '0;
      dir_q        <= 1'b1;
      clear_q      <= 1'b0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      clear_q      <= clear_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  assign sched_io.current_floor         = floor_q;
  assign sched_io.clear_current_request = clear_q;
  assign sched_io.direction             = dir_q;
  assign sched_io.door_open             = (state_q == S_DOOR_OPEN);
  assign sched_io.moving                = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
  assign sched_io.idle                  = (state_q == S_EVAL) && (sched_io.floor_requests == '0);

endmodule

`default_nettype wire

// File: tb/tb_floor_scheduler.sv
// ============================================================================
//  Module      : tb_floor_scheduler
//  Description : Self-checking bench for floor_scheduler with a behavioural
//                car model and a simple request-handler model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_floor_scheduler;

  localparam int NF = 10;
  localparam int FW = 4;
  localparam int TC = 4;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  floor_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_WIDTH(FW)) bus ();

  floor_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_WIDTH(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sched_io (bus)
  );

  // Handler request vector and car model (phase: 0 evaluate, 1 travel, 2 door).
  logic [NF-1:0] req;
  int            m_phase, m_floor, m_left;
  logic          m_dir, m_clr;
  int            n_vec, n_err;
  int            clr_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_floor = 0; m_left = 0; m_dir = 1'b1; m_clr = 1'b0;
  endtask

  // One clock edge of the car: sweep on while work lies ahead, else turn round.
  task automatic model_step(input logic hold);
    logic here, above, below;
    here = 1'b0; above = 1'b0; below = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (req[i]) begin
        if (i == m_floor) here  = 1'b1;
        if (i >  m_floor) above = 1'b1;
        if (i <  m_floor) below = 1'b1;
      end
    end
    m_clr = 1'b0;
    case (m_phase)
      0: begin
        if (here) begin
          m_phase = 2; m_left = DC; m_clr = 1'b1;
        end else if (above || below) begin
          if (!(m_dir ? above : below)) m_dir = !m_dir;
          m_phase = 1; m_left = TC;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = m_dir ? ((m_floor < NF-1) ? m_floor + 1 : m_floor)
                          : ((m_floor > 0)    ? m_floor - 1 : m_floor);
          m_phase = 0;
        end
      end
      default: begin
        if (hold) m_left = DC;
        else      m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
  endtask

  task automatic check_all();
    chk("current_floor", 32'(bus.current_floor), 32'(m_floor));
    chk("clear_pulse",   32'(bus.clear_current_request), 32'(m_clr));
    chk("door_open",     32'(bus.door_open), 32'(m_phase == 2));
    chk("moving",        32'(bus.moving), 32'(m_phase == 1));
    chk("direction",     32'(bus.direction), 32'(m_dir));
    chk("idle",          32'(bus.idle), 32'(m_phase == 0 && req == '0));
    if (bus.clear_current_request === 1'b1) clr_log.push_back(int'(bus.current_floor));
  endtask

  // Called at a falling edge: handler retires/sets bits, then one rising edge.
  task automatic tick(input logic [NF-1:0] set_bits, input logic hold);
    logic [NF-1:0] msk;
    msk = '0;
    if (m_clr) msk[m_floor] = 1'b1;
    req = (req & ~msk) | set_bits;
    bus.floor_requests = req;
    bus.door_hold      = hold;
    @(posedge clk);
    model_step(hold);
    @(negedge clk);
    check_all();
  endtask

  // Async reset mid-cycle, outputs checked before the next rising edge.
  task automatic do_reset();
    req = '0;
    bus.floor_requests = req;
    bus.door_hold      = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_floor", 32'(bus.current_floor), 0);
    chk("rst_clear", 32'(bus.clear_current_request), 0);
    chk("rst_door",  32'(bus.door_open), 0);
    chk("rst_move",  32'(bus.moving), 0);
    chk("rst_dir",   32'(bus.direction), 1);
    chk("rst_idle",  32'(bus.idle), 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    int k;
    k = 0;
    do begin
      tick('0, 1'b0);
      k++;
    end while (!(m_phase == 0 && req == '0) && k < max);
    chk("idle_within_bound", 32'(m_phase == 0 && req == '0), 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    req = '0;
    reset = 1'b1;
    bus.floor_requests = '0;
    bus.door_hold      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request at floor 3 from floor 0.
    tick(10'b0000001000, 1'b0);
    for (int e = 1; e <= 23; e++) begin
      tick('0, 1'b0);
      if (e == 4)  chk("t1_floor1_at_4", 32'(bus.current_floor), 1);
      if (e == 14) chk("t1_floor3_at_14", 32'(bus.current_floor), 3);
      if (e == 15) chk("t1_clear_at_15", 32'(bus.clear_current_request), 1);
      if (e == 22) chk("t1_door_at_22", 32'(bus.door_open), 1);
      if (e == 23) chk("t1_idle_at_23", 32'(bus.idle), 1);
    end

    // Sweep: reach 5 heading up, then requests at 2 and 7.
    tick(10'b0000100000, 1'b0);
    run_until_idle(200);
    chk("t2_at5", 32'(bus.current_floor), 5);
    clr_log.delete();
    tick(10'b0010000100, 1'b0);
    run_until_idle(300);
    chk("t2_pulses", 32'(clr_log.size()), 2);
    if (clr_log.size() == 2) begin
      chk("t2_first_7", 32'(clr_log[0]), 7);
      chk("t2_second_2", 32'(clr_log[1]), 2);
    end
    chk("t2_dir_down", 32'(bus.direction), 0);

    // Request at the current floor, then door hold for 5 cycles.
    tick(10'b0000000100, 1'b0);
    chk("t3_door", 32'(bus.door_open), 1);
    chk("t3_clear", 32'(bus.clear_current_request), 1);
    chk("t3_nomove", 32'(bus.moving), 0);
    repeat (5) tick('0, 1'b1);
    begin
      int n;
      n = 0;
      while (bus.door_open === 1'b1 && n < 20) begin
        tick('0, 1'b0);
        n++;
      end
      chk("t3_close_after_release", 32'(n), 8);
    end

    // Re-request of the same floor while the door is open.
    clr_log.delete();
    tick(10'b0000000100, 1'b0);
    tick('0, 1'b0);
    tick(10'b0000000100, 1'b0);
    run_until_idle(100);
    chk("t4_pulses", 32'(clr_log.size()), 2);

    // Bounds: service at floor 0 from 0 and at floor 9 from 9.
    tick(10'b0000000001, 1'b0);
    run_until_idle(200);
    tick(10'b0000000001, 1'b0);
    chk("t5_door_at0", 32'(bus.door_open), 1);
    run_until_idle(100);
    chk("t5_floor0", 32'(bus.current_floor), 0);
    tick(10'b1000000000, 1'b0);
    run_until_idle(200);
    tick(10'b1000000000, 1'b0);
    chk("t5_door_at9", 32'(bus.door_open), 1);
    run_until_idle(100);
    chk("t5_floor9", 32'(bus.current_floor), 9);

    // Reset while travelling up from floor 4.
    do_reset();
    tick(10'b0100000000, 1'b0);
    begin
      int k;
      k = 0;
      while (!(m_phase == 1 && m_floor == 4) && k < 100) begin
        tick('0, 1'b0);
        k++;
      end
      chk("t6_reached_move_at4", 32'(k < 100), 1);
    end
    tick('0, 1'b0);
    do_reset();
    tick(10'b0001000000, 1'b0);
    run_until_idle(200);
    chk("t6_resume_floor6", 32'(bus.current_floor), 6);

    // Randomised traffic with occasional holds and resets.
    for (int c = 0; c < 3000; c++) begin
      logic [NF-1:0] s;
      s = '0;
      if ($urandom_range(0, 5) == 0) s[$urandom_range(0, NF-1)] = 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        tick(s, ($urandom_range(0, 15) == 0));
      end
    end
    run_until_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
